// File: rtl/serial_ctrl_pkg.sv
// Shared definitions for the serial frame receiver: state encoding,
// default geometry and a width helper for counters.
package serial_ctrl_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_DIV    = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;

    // Counter width able to hold 0..value-1, never narrower than one bit.
    function automatic int min1_clog2(input int value);
        return (value > 1) ? $clog2(value) : 1;
    endfunction

endpackage

// File: rtl/sipo_shift.sv
// Serial-in parallel-out shift register; each enabled shift moves the
// register one place toward bit 0 and inserts din at the MSB (LSB-first line).
module sipo_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_en,
    input  logic              din,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] r_q;
    logic [DATA_W-1:0] w_q_next;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_bit
            if (gi == DATA_W - 1) begin : g_msb
                assign w_q_next[gi] = din;
            end else begin : g_low
                assign w_q_next[gi] = r_q[gi+1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (shift_en) begin
            r_q <= w_q_next;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial frame receiver: detects a start bit, samples din mid-bit every DIV
// clocks, checks optional even parity and the stop bit, and holds the frame for a consumer.
module serial_frame_ctrl
    import serial_ctrl_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DIV       = DEFAULT_DIV,
    parameter int PARITY_EN = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);

    localparam int DIV_W = min1_clog2(DIV);
    localparam int CNT_W = min1_clog2(DATA_W);

    localparam logic [DIV_W-1:0] HALF_LAST = DIV_W'(DIV / 2 - 1);
    localparam logic [DIV_W-1:0] FULL_LAST = DIV_W'(DIV - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DATA_W - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [DIV_W-1:0]  r_div;
    logic [DIV_W-1:0]  w_div_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              r_par;
    logic              w_par_next;
    logic [DATA_W-1:0] r_dout;
    logic [DATA_W-1:0] w_dout_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_perr;
    logic              w_perr_next;
    logic              r_ferr;
    logic              w_ferr_next;
    logic              r_ovr;
    logic              w_ovr_next;

    logic              w_shift_en;
    logic [DATA_W-1:0] w_shift_q;
    logic              w_tick_half;
    logic              w_tick_full;

    sipo_shift #(
        .DATA_W(DATA_W)
    ) u_sipo (
        .clk     (clk),
        .rst     (rst),
        .shift_en(w_shift_en),
        .din     (din),
        .q       (w_shift_q)
    );

    assign w_tick_half = (r_div == HALF_LAST);
    assign w_tick_full = (r_div == FULL_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_par   <= 1'b0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_div   <= w_div_next;
            r_cnt   <= w_cnt_next;
            r_par   <= w_par_next;
            r_dout  <= w_dout_next;
            r_valid <= w_valid_next;
            r_perr  <= w_perr_next;
            r_ferr  <= w_ferr_next;
            r_ovr   <= w_ovr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_div_next   = r_div;
        w_cnt_next   = r_cnt;
        w_par_next   = r_par;
        w_dout_next  = r_dout;
        w_valid_next = r_valid;
        w_perr_next  = r_perr;
        w_ferr_next  = 1'b0;
        w_ovr_next   = r_ovr;
        w_shift_en   = 1'b0;

        // A handshake frees the output register; a frame landing this same edge refills it below.
        if (r_valid && dout_ready) begin
            w_valid_next = 1'b0;
        end

        case (r_state)
            ST_IDLE: begin
                if (!din) begin
                    w_state_next = ST_START;
                    w_div_next   = '0;
                    w_cnt_next   = '0;
                    w_par_next   = 1'b0;
                end
            end

            ST_START: begin
                if (w_tick_half) begin
                    w_div_next   = '0;
                    w_state_next = din ? ST_IDLE : ST_DATA;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            ST_DATA: begin
                if (w_tick_full) begin
                    w_div_next = '0;
                    w_shift_en = 1'b1;
                    if (r_cnt == BIT_LAST) begin
                        w_cnt_next   = '0;
                        w_state_next = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        w_cnt_next = r_cnt + 1'b1;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            ST_PARITY: begin
                if (w_tick_full) begin
                    w_div_next   = '0;
                    w_par_next   = din ^ (^w_shift_q);
                    w_state_next = ST_STOP;
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            ST_STOP: begin
                if (w_tick_full) begin
                    w_div_next = '0;
                    if (din) begin
                        w_state_next = ST_IDLE;
                        if (!r_valid || dout_ready) begin
                            w_dout_next  = w_shift_q;
                            w_perr_next  = (PARITY_EN != 0) ? r_par : 1'b0;
                            w_valid_next = 1'b1;
                        end else begin
                            w_ovr_next = 1'b1;
                        end
                    end else begin
                        w_ferr_next  = 1'b1;
                        w_state_next = ST_BREAK;
                    end
                end else begin
                    w_div_next = r_div + 1'b1;
                end
            end

            ST_BREAK: begin
                if (din) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign dout       = r_dout;
    assign dout_valid = r_valid;
    assign parity_err = r_perr;
    assign frame_err  = r_ferr;
    assign overrun    = r_ovr;
    assign busy       = (r_state != ST_IDLE);

endmodule

// File: doc/serial_frame_ctrl.md
SERIAL_FRAME_CTRL -- requirements
Module: serial_frame_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data bits per frame.
REQ-002 Parameter DIV, default 4: clocks per serial bit; SHALL be even and >= 2.
REQ-003 Parameter PARITY_EN, default 1: 1 = even-parity bit follows data, 0 = no parity bit.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  reset; asynchronous, active-low.
REQ-006 din  input  1  serial line, synchronous to clk; idle high.
REQ-007 dout  output  DATA_W  last received frame data, LSB received first.
REQ-008 dout_valid  output  1  dout holds an unconsumed frame.
REQ-009 dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-010 parity_err  output  1  parity mismatch for the frame in dout; meaningful only while dout_valid=1.
REQ-011 frame_err  output  1  one-cycle pulse: stop bit sampled as 0.
REQ-012 overrun  output  1  sticky: a good frame was dropped because dout was still unconsumed.
REQ-013 busy  output  1  high in every state except IDLE.

Function
REQ-014 States SHALL be IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-015 IDLE: din=0 at an edge (the detection edge) -> START; bit counter=0, divider=0.
REQ-016 START: din is sampled DIV/2 clocks after the detection edge; 0 -> DATA, 1 -> IDLE (false start, no flags).
REQ-017 Every later sample SHALL occur exactly DIV clocks after the previous sample.
REQ-018 DATA: each sample shifts din into the shift register, LSB first; after DATA_W samples -> PARITY if PARITY_EN=1, else STOP.
REQ-019 PARITY: error = XOR of the sampled bit and all data bits = 1 (even parity); -> STOP.
REQ-020 STOP, sampled 1: dout, parity_err and dout_valid=1 are loaded at that edge, subject to REQ-022; -> IDLE.
REQ-021 STOP, sampled 0: frame_err pulses for one cycle, data discarded, dout unchanged -> BREAK; BREAK -> IDLE on the first edge with din=1.
REQ-022 Good stop while dout_valid=1 and dout_ready=0: the new frame is dropped, dout is kept and overrun is set.
REQ-023 Good stop in the same cycle as a dout_valid & dout_ready handshake: the new frame is loaded, dout_valid stays 1, no overrun.
REQ-024 dout_valid & dout_ready with no frame completing: dout_valid clears next edge; dout holds its value.
REQ-025 dout and parity_err SHALL NOT change while dout_valid=1 except per REQ-023.
REQ-026 Latency: good-stop sample edge = detection edge + DIV/2 + DIV*(DATA_W+PARITY_EN+1) clocks.
REQ-027 overrun clears only on reset.
REQ-028 din is ignored in IDLE except for start detection; a new start may be detected on the first edge after returning to IDLE.

Reset
REQ-029 While rst=0: state=IDLE; dout=0; dout_valid, parity_err, frame_err and overrun=0; counters and shift register=0; busy=0.
REQ-030 Reset asserted mid-frame SHALL discard the partial frame; after release, the block waits in IDLE for a fresh start bit.

Structure
REQ-031 Shared package serial_ctrl_pkg SHALL hold the state encoding constants and the default DATA_W/DIV values.
REQ-032 The data shift register SHALL be a sub-module sipo_shift (parameter DATA_W; ports clk, rst, shift_en, din, q).
REQ-033 FSM, divider and bit counter SHALL reside in serial_frame_ctrl; counter widths SHALL be derived by clog2.

Verification
REQ-034 DIV=4, DATA_W=8, PARITY_EN=1; frame 0xA5 with parity 0, stop 1; detection at edge 0, dout_ready=1 -> dout_valid rises at edge 42, dout=0xA5, parity_err=0.
REQ-035 Same frame with parity bit 1 -> dout=0xA5, dout_valid=1, parity_err=1.
REQ-036 Stop bit 0 -> frame_err high exactly one cycle at edge 42, dout_valid stays 0; with din held 0 the block stays in BREAK (busy=1); din=1 -> IDLE.
REQ-037 din low for 1 clock only -> START, sample at edge 2 reads 1 -> IDLE, no outputs change.
REQ-038 Two frames 0x11, 0x22 back to back, dout_ready=0 -> dout=0x11, overrun=1; repeat with dout_ready pulsed on the second stop-sample edge -> dout=0x22, overrun=0.
REQ-039 rst driven low at edge 20 mid-frame -> all outputs 0 immediately; after release, a full 0x3C frame is received correctly.
